// File: rtl/gc_pkg.sv
// Global codebase constants shared across blocks.
package gc;
  localparam int WORD_SIZE      = 32;
  localparam int VGA_MEM_OFFSET = 'h1000;
endpackage

// File: rtl/vga_pkg.sv
// VGA text-mode constants, index types and the fetch sequencer state encoding.
package vga_pkg;
  localparam int CHARS_HORZ = 80;
  localparam int CHARS_VERT = 30;
  localparam int ASCII_SIZE = 8;
  localparam int CPW        = gc::WORD_SIZE / ASCII_SIZE;
  localparam int WORDS      = CHARS_HORZ * CHARS_VERT / CPW;

  typedef logic [$clog2(CHARS_VERT)-1:0] row_t;
  typedef logic [$clog2(CHARS_HORZ)-1:0] col_t;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, UNPACK, DONE} fetch_state_t;
endpackage

// File: rtl/vga_char_fetch_word_unpacker.sv
// Holds one memory word and presents its ASCII slots MSB-first, one per shift.
module word_unpacker #(
  parameter int WORD_SIZE  = 32,
  parameter int ASCII_SIZE = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [WORD_SIZE-1:0]  loadData,
  input  logic                  shift,
  output logic [ASCII_SIZE-1:0] slotData,
  output logic                  last
);
  localparam int CPW = WORD_SIZE / ASCII_SIZE;
  localparam int SW  = (CPW > 1) ? $clog2(CPW) : 1;

  logic [WORD_SIZE-1:0] shReg;
  logic [SW-1:0]        slot;

  // Load a fresh word, or move the next slot into the top position.
  always_ff @(posedge clk) begin
    if (rst) begin
      shReg <= '0;
      slot  <= '0;
    end else if (load) begin
      shReg <= loadData;
      slot  <= '0;
    end else if (shift) begin
      shReg <= shReg << ASCII_SIZE;
      slot  <= slot + SW'(1);
    end
  end

  assign slotData = shReg[WORD_SIZE-1 -: ASCII_SIZE];
  assign last     = (slot == SW'(CPW-1));
endmodule

// File: rtl/vga_char_fetch.sv
// Frame sequencer: reads the VGA text region word by word and writes each
// character with its row/column into the character buffer.
// Optional: define VGA_FETCH_AUTORUN_EN for continuous frame refresh without start.
module vga_char_fetch
  import vga_pkg::*;
#(
  parameter int WORD_SIZE      = gc::WORD_SIZE,
  parameter int ASCII_SIZE     = vga_pkg::ASCII_SIZE,
  parameter int CHARS_HORZ     = vga_pkg::CHARS_HORZ,
  parameter int CHARS_VERT     = vga_pkg::CHARS_VERT,
  parameter int VGA_MEM_OFFSET = gc::VGA_MEM_OFFSET,
  parameter int MEM_LATENCY    = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic                          mem_rd_en,
  output logic [WORD_SIZE-1:0]          mem_rd_addr,
  input  logic [WORD_SIZE-1:0]          mem_rd_data,
  output logic                          ch_wr_en,
  output logic [$clog2(CHARS_VERT)-1:0] ch_wr_row,
  output logic [$clog2(CHARS_HORZ)-1:0] ch_wr_col,
  output logic [ASCII_SIZE-1:0]         ch_wr_data,
  output logic                          busy,
  output logic                          done
);
  localparam int NCPW   = WORD_SIZE / ASCII_SIZE;
  localparam int NWORDS = CHARS_HORZ * CHARS_VERT / NCPW;
  localparam int RW     = $clog2(CHARS_VERT);
  localparam int CW     = $clog2(CHARS_HORZ);
  localparam int WIW    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int LW     = $clog2(MEM_LATENCY + 1);

  if ((CHARS_HORZ % NCPW) != 0) begin : gRowAlign
    $error("CHARS_HORZ must be a multiple of characters per word");
  end
  if (MEM_LATENCY < 1) begin : gLatency
    $error("MEM_LATENCY must be at least 1");
  end

  fetch_state_t    state, nextState;
  logic [WIW-1:0]  wordIdx;
  logic [RW-1:0]   row;
  logic [CW-1:0]   col;
  logic [LW-1:0]   waitCnt;
  logic            waitLast, wordLast, slotLast;
  logic [ASCII_SIZE-1:0] slotData;

  assign waitLast = (waitCnt == LW'(MEM_LATENCY-1));
  assign wordLast = (wordIdx == WIW'(NWORDS-1));

  // State register; reset always wins over start.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // Next-state: one request, MEM_LATENCY waits, CPW character writes per word.
  always_comb begin
    nextState = state;
    case (state)
`ifdef VGA_FETCH_AUTORUN_EN
      IDLE:   nextState = REQ;
`else
      IDLE:   if (start) nextState = REQ;
`endif
      REQ:    nextState = WAIT;
      WAIT:   if (waitLast) nextState = UNPACK;
      UNPACK: if (slotLast) nextState = wordLast ? DONE : REQ;
`ifdef VGA_FETCH_AUTORUN_EN
      DONE:   nextState = REQ;
`else
      DONE:   nextState = IDLE;
`endif
      default: nextState = IDLE;
    endcase
  end

  // Latency counter, word index and screen position bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      waitCnt <= '0;
      wordIdx <= '0;
      row     <= '0;
      col     <= '0;
    end else begin
      case (state)
        REQ:  waitCnt <= '0;
        WAIT: waitCnt <= waitCnt + LW'(1);
        UNPACK: begin
          if (col == CW'(CHARS_HORZ-1)) begin
            col <= '0;
            // final character of the frame must not push row past the last line
            row <= (row == RW'(CHARS_VERT-1)) ? '0 : row + RW'(1);
          end else begin
            col <= col + CW'(1);
          end
          if (slotLast && !wordLast) wordIdx <= wordIdx + WIW'(1);
        end
        DONE: begin
          wordIdx <= '0;
          row     <= '0;
          col     <= '0;
        end
        default: ;
      endcase
    end
  end

  word_unpacker #(.WORD_SIZE(WORD_SIZE), .ASCII_SIZE(ASCII_SIZE)) uUnpack (
    .clk      (clk),
    .rst      (rst),
    .load     ((state == WAIT) && waitLast),
    .loadData (mem_rd_data),
    .shift    (state == UNPACK),
    .slotData (slotData),
    .last     (slotLast)
  );

  assign mem_rd_en   = (state == REQ);
  assign mem_rd_addr = mem_rd_en ? WORD_SIZE'(VGA_MEM_OFFSET) + WORD_SIZE'(wordIdx) : '0;
  assign ch_wr_en    = (state == UNPACK);
  assign ch_wr_row   = row;
  assign ch_wr_col   = col;
  assign ch_wr_data  = ch_wr_en ? slotData : '0;
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
endmodule
